// File: rtl/aoc4_pkg.sv
// ----------------------------------------------------------------------------
// aoc4_pkg
// Shared types and constants for the day-4 roll-grid loader and bank array.
//  - tb_packet_t    : staged row/col write packet sent to the bank array
//  - CH_*           : ASCII bytes understood by the loader
//  - loader_state_e : grid_loader FSM states
//  - width defaults : default vector width and grid capacity
// ----------------------------------------------------------------------------
package aoc4_pkg;

    localparam int unsigned TX_DATA_WIDTH = 64;
    localparam int unsigned MAX_ROWS_DEF  = 256;
    localparam int unsigned MAX_COLS_DEF  = 256;

    // Address fields are sized for the largest legal grid so that any
    // TX_W / MAX_ROWS / MAX_COLS choice fits; narrower builds zero-extend.
    localparam int unsigned PKT_ROW_W = 8;
    localparam int unsigned PKT_COL_W = 8;

    typedef struct packed {
        logic                     staging;
        logic                     write_en;
        logic                     read_en;
        logic [PKT_ROW_W-1:0]     row_addr;
        logic [PKT_COL_W-1:0]     col_addr;
        logic [TX_DATA_WIDTH-1:0] partial_vec;
    } tb_packet_t;

    localparam logic [7:0] CH_ROLL  = 8'h40;  // '@'
    localparam logic [7:0] CH_EMPTY = 8'h2E;  // '.'
    localparam logic [7:0] CH_NL    = 8'h0A;  // '\n'
    localparam logic [7:0] CH_CR    = 8'h0D;  // '\r'

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StIssue,
        StWaitAck,
        StDone
    } loader_state_e;

endpackage

// File: rtl/grid_loader_row_packer.sv
// ----------------------------------------------------------------------------
// row_packer
// Packs grid cells into a TX_W-bit partial vector, bit 0 = leftmost column.
// Ports:
//  i_clk, i_rst_n : clock, asynchronous active-low reset
//  i_clear        : drop the vector and restart at bit 0 (start / after ack)
//  i_push, i_bit  : append one cell at the current bit index
//  o_vec          : packed vector (unfilled bits are 0)
//  o_empty        : no cells held
//  o_last         : next push fills the vector
// ----------------------------------------------------------------------------
module row_packer #(
    parameter int unsigned TX_W = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_bit,
    output logic [TX_W-1:0] o_vec,
    output logic            o_empty,
    output logic            o_last
);

    localparam int unsigned IDX_W = $clog2(TX_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_W - 1);

    logic [IDX_W-1:0] r_idx;
    logic [TX_W-1:0]  r_vec;
    logic [TX_W-1:0]  w_bit_vec;

    assign w_bit_vec = {{(TX_W - 1){1'b0}}, i_bit};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
            r_vec <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
            r_vec <= '0;
        end else if (i_push) begin
            r_idx <= r_idx + 1'b1;
            r_vec <= r_vec | (w_bit_vec << r_idx);
        end
    end

    assign o_vec   = r_vec;
    assign o_empty = (r_idx == '0);
    assign o_last  = (r_idx == LAST_IDX);

endmodule

// File: rtl/grid_loader.sv
// ----------------------------------------------------------------------------
// grid_loader
// Parses the puzzle text ('@', '.', '\n') one byte per cycle, packs each row
// into TX_W-bit vectors and writes them to the bank array one at a time,
// waiting for the bank ack between writes. Reports grid height/width.
// Ports:
//  clock, reset          : clock, asynchronous active-low reset
//  start_in              : pulse, begin a load (only in idle/done)
//  char_valid/char_in    : input byte stream, accepted when char_ready
//  char_ready            : loader can take a byte this cycle
//  eof_in                : level, stream exhausted
//  mem_ack_in            : bank ack for the pending write
//  pkt_out               : staged write packet
//  rows_out, cols_out    : grid height / width of row 0 (valid with done_out)
//  done_out              : load finished, held until the next start_in
//  err_out               : sticky: bad byte, ragged row, row/col overflow
// ----------------------------------------------------------------------------
module grid_loader
    import aoc4_pkg::*;
#(
    parameter  int unsigned TX_W     = TX_DATA_WIDTH,
    parameter  int unsigned MAX_ROWS = MAX_ROWS_DEF,
    parameter  int unsigned MAX_COLS = MAX_COLS_DEF,
    localparam int unsigned ROW_W    = $clog2(MAX_ROWS),
    localparam int unsigned CNT_W    = $clog2(MAX_COLS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_in,
    input  logic             char_valid,
    input  logic [7:0]       char_in,
    output logic             char_ready,
    input  logic             eof_in,
    input  logic             mem_ack_in,
    output tb_packet_t       pkt_out,
    output logic [ROW_W:0]   rows_out,
    output logic [CNT_W-1:0] cols_out,
    output logic             done_out,
    output logic             err_out
);

    localparam int unsigned COL_W = (MAX_COLS / TX_W > 1) ? $clog2(MAX_COLS / TX_W) : 1;
    localparam logic [ROW_W:0]   ROW_LIMIT = MAX_ROWS[ROW_W:0];
    localparam logic [CNT_W-1:0] COL_LIMIT = MAX_COLS[CNT_W-1:0];

    loader_state_e    r_state, w_state_d;
    logic [ROW_W:0]   r_row, w_row_d;
    logic [COL_W-1:0] r_col_addr, w_col_addr_d;
    logic [CNT_W-1:0] r_col_cnt, w_col_cnt_d;
    logic [CNT_W-1:0] r_cols, w_cols_d;
    logic             r_err, w_err_d;
    logic             r_nl_pend, w_nl_pend_d;   // pending write is a row-end flush
    logic             r_eof_pend, w_eof_pend_d; // finish once the pending write is acked

    logic             w_end_row, w_eof_now;
    logic             w_pk_clear, w_pk_push, w_pk_bit, w_pk_empty, w_pk_last;
    logic [TX_W-1:0]  w_vec;

    row_packer #(
        .TX_W (TX_W)
    ) u_row_packer (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clear (w_pk_clear),
        .i_push  (w_pk_push),
        .i_bit   (w_pk_bit),
        .o_vec   (w_vec),
        .o_empty (w_pk_empty),
        .o_last  (w_pk_last)
    );

    always_comb begin
        w_state_d    = r_state;
        w_row_d      = r_row;
        w_col_addr_d = r_col_addr;
        w_col_cnt_d  = r_col_cnt;
        w_cols_d     = r_cols;
        w_err_d      = r_err;
        w_nl_pend_d  = r_nl_pend;
        w_eof_pend_d = r_eof_pend;
        w_pk_clear   = 1'b0;
        w_pk_push    = 1'b0;
        w_pk_bit     = 1'b0;
        w_end_row    = 1'b0;
        w_eof_now    = 1'b0;

        unique case (r_state)
            StIdle, StDone: begin
                if (start_in) begin
                    w_state_d    = StFill;
                    w_row_d      = '0;
                    w_col_addr_d = '0;
                    w_col_cnt_d  = '0;
                    w_cols_d     = '0;
                    w_err_d      = 1'b0;
                    w_nl_pend_d  = 1'b0;
                    w_eof_pend_d = 1'b0;
                    w_pk_clear   = 1'b1;
                end
            end
            StFill: begin
                // A valid byte takes priority over eof in the same cycle.
                if (char_valid) begin
                    case (char_in)
                        CH_ROLL, CH_EMPTY: begin
                            if (r_row == ROW_LIMIT || r_col_cnt == COL_LIMIT) begin
                                w_err_d = 1'b1;
                            end else begin
                                w_pk_push   = 1'b1;
                                w_pk_bit    = (char_in == CH_ROLL);
                                w_col_cnt_d = r_col_cnt + 1'b1;
                                if (w_pk_last) w_state_d = StIssue;
                            end
                        end
                        CH_NL:   w_end_row = (r_col_cnt != '0);
                        CH_CR:   w_end_row = 1'b0;
                        default: w_err_d = 1'b1;
                    endcase
                end else if (eof_in) begin
                    w_eof_now = 1'b1;
                    w_end_row = (r_col_cnt != '0);
                    if (r_col_cnt == '0) w_state_d = StDone;
                end

                if (w_end_row) begin
                    w_col_cnt_d = '0;
                    if (r_row == '0) begin
                        w_cols_d = r_col_cnt;
                    end else if (r_col_cnt != r_cols) begin
                        w_err_d = 1'b1;
                    end
                    if (!w_pk_empty) begin
                        // Row advance waits for the flush ack so the packet keeps its row.
                        w_state_d    = StIssue;
                        w_nl_pend_d  = 1'b1;
                        w_eof_pend_d = w_eof_now;
                    end else begin
                        w_row_d      = r_row + 1'b1;
                        w_col_addr_d = '0;
                        if (w_eof_now) w_state_d = StDone;
                    end
                end
            end
            StIssue: w_state_d = StWaitAck;
            StWaitAck: begin
                if (mem_ack_in) begin
                    w_pk_clear   = 1'b1;
                    w_nl_pend_d  = 1'b0;
                    w_eof_pend_d = 1'b0;
                    w_state_d    = r_eof_pend ? StDone : StFill;
                    if (r_nl_pend) begin
                        w_row_d      = r_row + 1'b1;
                        w_col_addr_d = '0;
                    end else begin
                        w_col_addr_d = r_col_addr + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_row      <= '0;
            r_col_addr <= '0;
            r_col_cnt  <= '0;
            r_cols     <= '0;
            r_err      <= 1'b0;
            r_nl_pend  <= 1'b0;
            r_eof_pend <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_row      <= w_row_d;
            r_col_addr <= w_col_addr_d;
            r_col_cnt  <= w_col_cnt_d;
            r_cols     <= w_cols_d;
            r_err      <= w_err_d;
            r_nl_pend  <= w_nl_pend_d;
            r_eof_pend <= w_eof_pend_d;
        end
    end

    always_comb begin
        pkt_out             = '0;
        pkt_out.staging     = (r_state == StFill) || (r_state == StIssue) ||
                              (r_state == StWaitAck);
        pkt_out.write_en    = (r_state == StIssue);
        pkt_out.read_en     = 1'b0;
        pkt_out.row_addr    = PKT_ROW_W'(r_row[ROW_W-1:0]);
        pkt_out.col_addr    = PKT_COL_W'(r_col_addr);
        pkt_out.partial_vec = TX_DATA_WIDTH'(w_vec);
    end

    assign char_ready = (r_state == StFill);
    assign done_out   = (r_state == StDone);
    assign err_out    = r_err;
    assign rows_out   = r_row;
    assign cols_out   = r_cols;

endmodule

// File: tb/tb_grid_loader.sv
module tb_grid_loader;
    import aoc4_pkg::*;

    localparam int TXW = 8;
    localparam int MR  = 4;
    localparam int MC  = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_in = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       eof_in = 1'b0;
    logic       mem_ack_in = 1'b0;
    logic       char_ready, done_out, err_out;
    tb_packet_t pkt_out;
    logic [2:0] rows_out;
    logic [4:0] cols_out;

    typedef struct {
        int row;
        int col;
        int vec;
    } wr_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    bit         m_cur[$];
    int         m_rows, m_cols;
    bit         m_err;
    int         proto_bad;
    bit         timed_out;
    int         n_vec = 0;
    int         n_bad = 0;

    grid_loader #(
        .TX_W     (TXW),
        .MAX_ROWS (MR),
        .MAX_COLS (MC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_in   (start_in),
        .char_valid (char_valid),
        .char_in    (char_in),
        .char_ready (char_ready),
        .eof_in     (eof_in),
        .mem_ack_in (mem_ack_in),
        .pkt_out    (pkt_out),
        .rows_out   (rows_out),
        .cols_out   (cols_out),
        .done_out   (done_out),
        .err_out    (err_out)
    );

    always #5 clock = ~clock;

    function automatic void load_str(input string s);
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endfunction

    // Reference: a completed non-empty line becomes ceil(len/TXW) writes.
    function automatic void model_end_row();
        int sz = m_cur.size();
        if (sz == 0) return;
        if (m_rows == 0) m_cols = sz;
        else if (sz != m_cols) m_err = 1'b1;
        for (int k = 0; k * TXW < sz; k++) begin
            int v = 0;
            for (int b = 0; b < TXW; b++)
                if (k * TXW + b < sz && m_cur[k * TXW + b]) v = v | (1 << b);
            exp_q.push_back(wr_t'{m_rows, k, v});
        end
        m_rows++;
        m_cur.delete();
    endfunction

    function automatic void model();
        m_cur.delete();
        exp_q.delete();
        m_rows = 0;
        m_cols = 0;
        m_err  = 1'b0;
        foreach (stim_q[i]) begin
            if (stim_q[i] == 8'h40 || stim_q[i] == 8'h2E) begin
                if (m_rows == MR || m_cur.size() == MC) m_err = 1'b1;
                else m_cur.push_back(stim_q[i] == 8'h40);
            end else if (stim_q[i] == 8'h0A) begin
                model_end_row();
            end else if (stim_q[i] != 8'h0D) begin
                m_err = 1'b1;
            end
        end
        model_end_row();
    endfunction

    // Drives one load from stim_q and records writes; lat=0 means random ack latency.
    task automatic run_load(input int lat, input int gap_pct, input bit early_eof,
                            input int abort_at);
        int         idx = 0;
        int         cyc = 0;
        int         wait_n = 0;
        bit         pending = 1'b0;
        tb_packet_t held;
        got_q.delete();
        proto_bad = 0;
        timed_out = 1'b0;
        @(negedge clock);
        start_in = 1'b1;
        forever begin
            @(negedge clock);
            start_in = 1'b0;
            cyc++;
            if (done_out) break;
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            if (abort_at >= 0 && idx >= abort_at && !pending) break;
            if (!pkt_out.staging) proto_bad++;
            mem_ack_in = 1'b0;
            if (pending) begin
                if (pkt_out.write_en || char_ready || pkt_out.row_addr != held.row_addr ||
                    pkt_out.col_addr != held.col_addr ||
                    pkt_out.partial_vec != held.partial_vec) proto_bad++;
                if (wait_n <= 1) begin
                    mem_ack_in = 1'b1;
                    pending = 1'b0;
                end else begin
                    wait_n--;
                end
            end else if (pkt_out.write_en) begin
                if (char_ready) proto_bad++;
                got_q.push_back(wr_t'{int'(pkt_out.row_addr), int'(pkt_out.col_addr),
                                      int'(pkt_out.partial_vec)});
                held    = pkt_out;
                pending = 1'b1;
                wait_n  = (lat > 0) ? lat : int'($urandom_range(1, 4));
                // an ack during the issue cycle must be ignored
                mem_ack_in = (lat == 0) ? 1'($urandom % 2) : 1'b0;
            end
            char_valid = 1'b0;
            eof_in     = 1'b0;
            if (idx < stim_q.size()) begin
                if (int'($urandom_range(0, 99)) >= gap_pct) begin
                    char_valid = 1'b1;
                    char_in    = stim_q[idx];
                    eof_in     = early_eof && ($urandom % 2 == 1);
                    if (char_ready) idx++;
                end
            end else begin
                eof_in = 1'b1;
            end
        end
        char_valid = 1'b0;
        eof_in     = 1'b0;
        mem_ack_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_vec++;
        if (char_ready !== 1'b0 || done_out !== 1'b0 || err_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset flags got rdy=%b done=%b err=%b want 0 0 0",
                     char_ready, done_out, err_out);
        end
        n_vec++;
        if (rows_out !== 3'd0 || cols_out !== 5'd0) begin
            n_bad++;
            $display("FAIL reset dims got rows=%0d cols=%0d want 0 0", rows_out, cols_out);
        end
        n_vec++;
        if (pkt_out !== '0) begin
            n_bad++;
            $display("FAIL reset pkt got %h want 0", pkt_out);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        load_str("@.@.@.@.\n");
        run_load(1, 0, 1'b0, -1);
        exp_q.delete();
        exp_q.push_back(wr_t'{0, 0, 'h55});
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL basic nwr got %0d want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_vec++;
            if (got_q[i] != exp_q[i]) begin
                n_bad++;
                $display("FAIL basic wr%0d got r%0d c%0d v%0h want r%0d c%0d v%0h", i,
                         got_q[i].row, got_q[i].col, got_q[i].vec,
                         exp_q[i].row, exp_q[i].col, exp_q[i].vec);
            end
        end
        n_vec++;
        if (timed_out || done_out !== 1'b1 || err_out !== 1'b0 || rows_out !== 3'd1 ||
            cols_out !== 5'd8) begin
            n_bad++;
            $display("FAIL basic result got to=%b done=%b err=%b rows=%0d cols=%0d want 0 1 0 1 8",
                     timed_out, done_out, err_out, rows_out, cols_out);
        end
    endtask

    task automatic test_two_rows();
        load_str("@@@\n..@\n");
        run_load(1, 0, 1'b0, -1);
        exp_q.delete();
        exp_q.push_back(wr_t'{0, 0, 'h07});
        exp_q.push_back(wr_t'{1, 0, 'h04});
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL two_rows nwr got %0d want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_vec++;
            if (got_q[i] != exp_q[i]) begin
                n_bad++;
                $display("FAIL two_rows wr%0d got r%0d c%0d v%0h want r%0d c%0d v%0h", i,
                         got_q[i].row, got_q[i].col, got_q[i].vec,
                         exp_q[i].row, exp_q[i].col, exp_q[i].vec);
            end
        end
        n_vec++;
        if (timed_out || done_out !== 1'b1 || err_out !== 1'b0 || rows_out !== 3'd2 ||
            cols_out !== 5'd3) begin
            n_bad++;
            $display("FAIL two_rows result got to=%b done=%b err=%b rows=%0d cols=%0d want 0 1 0 2 3",
                     timed_out, done_out, err_out, rows_out, cols_out);
        end
    endtask

    task automatic test_no_trailing_nl();
        load_str("@........@");
        run_load(1, 0, 1'b0, -1);
        exp_q.delete();
        exp_q.push_back(wr_t'{0, 0, 'h01});
        exp_q.push_back(wr_t'{0, 1, 'h02});
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL no_nl nwr got %0d want %0d", got_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_vec++;
            if (got_q[i] != exp_q[i]) begin
                n_bad++;
                $display("FAIL no_nl wr%0d got r%0d c%0d v%0h want r%0d c%0d v%0h", i,
                         got_q[i].row, got_q[i].col, got_q[i].vec,
                         exp_q[i].row, exp_q[i].col, exp_q[i].vec);
            end
        end
        n_vec++;
        if (timed_out || done_out !== 1'b1 || err_out !== 1'b0 || rows_out !== 3'd1 ||
            cols_out !== 5'd10) begin
            n_bad++;
            $display("FAIL no_nl result got to=%b done=%b err=%b rows=%0d cols=%0d want 0 1 0 1 10",
                     timed_out, done_out, err_out, rows_out, cols_out);
        end
    endtask

    task automatic test_ack_holdoff();
        load_str("@@@@@@@@@@\n");
        run_load(5, 0, 1'b0, -1);
        n_vec++;
        if (proto_bad != 0) begin
            n_bad++;
            $display("FAIL holdoff protocol got %0d violations want 0", proto_bad);
        end
        n_vec++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL holdoff nwr got %0d want 2", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0].vec != 'hff || got_q[1].col != 1 || got_q[1].vec != 'h03) begin
                n_bad++;
                $display("FAIL holdoff data got v%0h c%0d v%0h want vff c1 v03",
                         got_q[0].vec, got_q[1].col, got_q[1].vec);
            end
        end
        repeat (3) @(negedge clock);
        n_vec++;
        if (timed_out || done_out !== 1'b1 || pkt_out.staging !== 1'b0 || char_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL holdoff done_hold got to=%b done=%b stg=%b rdy=%b want 0 1 0 0",
                     timed_out, done_out, pkt_out.staging, char_ready);
        end
    endtask

    task automatic test_errors();
        load_str("@@\n@\n");
        run_load(1, 0, 1'b0, -1);
        n_vec++;
        if (timed_out || err_out !== 1'b1 || rows_out !== 3'd2 || cols_out !== 5'd2 ||
            got_q.size() != 2) begin
            n_bad++;
            $display("FAIL ragged got to=%b err=%b rows=%0d cols=%0d nwr=%0d want 0 1 2 2 2",
                     timed_out, err_out, rows_out, cols_out, got_q.size());
        end
        repeat (4) @(negedge clock);
        n_vec++;
        if (err_out !== 1'b1 || done_out !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky got err=%b done=%b want 1 1", err_out, done_out);
        end
        load_str("\n\n@.\r\n\n.@\n");
        run_load(2, 0, 1'b0, -1);
        n_vec++;
        if (timed_out || err_out !== 1'b0 || rows_out !== 3'd2 || got_q.size() != 2) begin
            n_bad++;
            $display("FAIL blank_lines got to=%b err=%b rows=%0d nwr=%0d want 0 0 2 2",
                     timed_out, err_out, rows_out, got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] != wr_t'{0, 0, 'h01} || got_q[1] != wr_t'{1, 0, 'h02}) begin
                n_bad++;
                $display("FAIL blank_data got r%0d v%0h r%0d v%0h want r0 v1 r1 v2",
                         got_q[0].row, got_q[0].vec, got_q[1].row, got_q[1].vec);
            end
        end
        load_str("@@\nx@@\n");
        run_load(1, 0, 1'b0, -1);
        n_vec++;
        if (timed_out || err_out !== 1'b1 || rows_out !== 3'd2 || got_q.size() != 2) begin
            n_bad++;
            $display("FAIL bad_char got to=%b err=%b rows=%0d nwr=%0d want 0 1 2 2",
                     timed_out, err_out, rows_out, got_q.size());
        end
        load_str("@@@@@@@@@@@@@@@@@\n@\n@\n@\n@\n");
        run_load(1, 0, 1'b0, -1);
        n_vec++;
        if (timed_out || err_out !== 1'b1 || rows_out !== 3'd4 || cols_out !== 5'd16 ||
            got_q.size() != 5) begin
            n_bad++;
            $display("FAIL overflow got to=%b err=%b rows=%0d cols=%0d nwr=%0d want 0 1 4 16 5",
                     timed_out, err_out, rows_out, cols_out, got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        load_str("x@@@@\n@@");
        run_load(1, 0, 1'b0, 8);
        n_vec++;
        if (err_out !== 1'b1 || rows_out !== 3'd1 || char_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset got err=%b rows=%0d rdy=%b want 1 1 1",
                     err_out, rows_out, char_ready);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (char_ready !== 1'b0 || done_out !== 1'b0 || err_out !== 1'b0 ||
            rows_out !== 3'd0 || cols_out !== 5'd0 || pkt_out !== '0) begin
            n_bad++;
            $display("FAIL mid_reset got rdy=%b done=%b err=%b rows=%0d cols=%0d pkt=%h want 0",
                     char_ready, done_out, err_out, rows_out, cols_out, pkt_out);
        end
        @(negedge clock);
        reset = 1'b1;
        load_str("..@\n");
        run_load(1, 0, 1'b0, -1);
        n_vec++;
        if (timed_out || err_out !== 1'b0 || rows_out !== 3'd1 || cols_out !== 5'd3 ||
            got_q.size() != 1) begin
            n_bad++;
            $display("FAIL after_reset got to=%b err=%b rows=%0d cols=%0d nwr=%0d want 0 0 1 3 1",
                     timed_out, err_out, rows_out, cols_out, got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] != wr_t'{0, 0, 'h04}) begin
                n_bad++;
                $display("FAIL after_reset wr got r%0d c%0d v%0h want r0 c0 v4",
                         got_q[0].row, got_q[0].col, got_q[0].vec);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int w = int'($urandom_range(1, 18));
            int h = int'($urandom_range(1, 5));
            stim_q.delete();
            for (int r = 0; r < h; r++) begin
                int len = w;
                if ($urandom_range(0, 9) == 0) stim_q.push_back(8'h0A);
                if ($urandom_range(0, 9) == 0) len = (w > 1) ? w - 1 : w + 1;
                for (int c = 0; c < len; c++) begin
                    if ($urandom_range(0, 39) == 0) stim_q.push_back(8'h78);
                    stim_q.push_back(($urandom % 2 == 1) ? 8'h40 : 8'h2E);
                end
                if ($urandom_range(0, 5) == 0) stim_q.push_back(8'h0D);
                if (r < h - 1 || $urandom % 2 == 1) stim_q.push_back(8'h0A);
            end
            model();
            run_load(0, 20, 1'b1, -1);
            n_vec++;
            if (got_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand%0d nwr got %0d want %0d", it, got_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                n_vec++;
                if (got_q[i] != exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d wr%0d got r%0d c%0d v%0h want r%0d c%0d v%0h", it, i,
                             got_q[i].row, got_q[i].col, got_q[i].vec,
                             exp_q[i].row, exp_q[i].col, exp_q[i].vec);
                end
            end
            n_vec++;
            if (timed_out || done_out !== 1'b1 || proto_bad != 0 || err_out !== m_err ||
                int'(rows_out) != m_rows || int'(cols_out) != m_cols) begin
                n_bad++;
                $display("FAIL rand%0d result got to=%b done=%b proto=%0d err=%b rows=%0d cols=%0d want 0 1 0 %b %0d %0d",
                         it, timed_out, done_out, proto_bad, err_out, rows_out, cols_out,
                         m_err, m_rows, m_cols);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_rows();
        test_no_trailing_nl();
        test_ack_holdoff();
        test_errors();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
